fifo_stream_reader: RTL and testbench

Downstream consumer of the team's synchronous FIFO. It drains the FIFO's rd/empty/rddata interface, where read data arrives one cycle after the read strobe, and presents a valid/ready streaming source. A 2-entry output buffer hides the read latency and sustains one beat per cycle. Beats are framed into fixed-length packets with start-of-packet and end-of-packet markers.

---
 rtl/fifo_stream_reader.sv | 111 +++++++++++
 tb/tb_fifo_stream_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO with one-cycle read latency into a framed valid/ready stream.
// A 2-entry buffer absorbs the read latency so one beat can move every cycle.
module fifo_stream_reader #(
  parameter int DWIDTH  = 8,
  parameter int PKT_LEN = 4,
  parameter int CWIDTH  = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_o,
  input  logic [DWIDTH-1:0] fifo_rddata_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              src_sop_o,
  output logic              src_eop_o,
  output logic [CWIDTH-1:0] pkt_cnt_o
);
  localparam logic [CWIDTH-1:0] LAST_BEAT = CWIDTH'(PKT_LEN - 1);
  localparam logic              EOP_RST   = (PKT_LEN == 1);

  logic [1:0]        r_occ;
  logic              r_inflight;
  logic [DWIDTH-1:0] r_head;
  logic [DWIDTH-1:0] r_tail;
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
  logic [CWIDTH-1:0] r_beat_cnt;
  logic [CWIDTH-1:0] r_pkt_cnt;

  logic              w_pop;
  logic [2:0]        w_level;
  logic              w_rd;
  logic [CWIDTH-1:0] w_beat_next;

  // w_level is buffered plus in-flight words net of this cycle's pop, i.e. next occupancy
  always_comb begin
    w_pop   = r_valid && src_ready_i;
    w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_rd    = !srst_i && !fifo_empty_i && (w_level < 3'd2);
    if (w_pop) begin
      if (r_eop) begin
        w_beat_next = '0;
      end else begin
        w_beat_next = r_beat_cnt + CWIDTH'(1);
      end
    end else begin
      w_beat_next = r_beat_cnt;
    end
  end

  // Buffer, occupancy and framing state
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= 1'b0;
      r_sop      <= 1'b1;
      r_eop      <= EOP_RST;
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      r_occ      <= w_level[1:0];
      r_inflight <= w_rd;
      r_valid    <= (w_level != 3'd0);
      r_beat_cnt <= w_beat_next;
      r_sop      <= (w_beat_next == '0);
      r_eop      <= (w_beat_next == LAST_BEAT);
      if (w_pop && r_eop) begin
        r_pkt_cnt <= r_pkt_cnt + CWIDTH'(1);
      end else begin
        r_pkt_cnt <= r_pkt_cnt;
      end
      // Returning data lands behind whatever survives this cycle's pop
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= fifo_rddata_i;
          end else begin
            r_tail <= fifo_rddata_i;
          end
        end
        2'b01: r_head <= r_tail;
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= fifo_rddata_i;
          end else begin
            r_head <= r_tail;
            r_tail <= fifo_rddata_i;
          end
        end
        default: begin
          r_head <= r_head;
          r_tail <= r_tail;
        end
      endcase
    end
  end

  assign fifo_rd_o   = w_rd;
  assign src_data_o  = r_head;
  assign src_valid_o = r_valid;
  assign src_sop_o   = r_sop;
  assign src_eop_o   = r_eop;
  assign pkt_cnt_o   = r_pkt_cnt;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a per-cycle vector table driving the FIFO side
// directly, then sequences against a small behavioural FIFO for multi-cycle cases.
module tb_fifo_stream_reader;
  logic       clk = 1'b0;
  logic       srst;
  logic       src_ready;
  logic       tb_empty;
  logic [7:0] tb_rddata;
  logic       use_model;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_rddata;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_sop;
  logic       src_eop;
  logic [7:0] pkt_cnt;

  logic [7:0] mem [64];
  int         wr_cnt = 0;
  int         rd_cnt;
  logic [7:0] m_rddata;

  int   total = 0;
  int   bad   = 0;
  int   nrd, nb, cyc;
  logic chk_inv = 1'b0;

  logic [7:0] b_data [16];
  logic       b_sop  [16];
  logic       b_eop  [16];
  logic [7:0] b_pkt  [16];
  int         b_cyc  [16];

  typedef struct {
    logic       empty;
    logic [7:0] rddata;
    logic       ready;
    logic       rd;
    logic       valid;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] pkt;
  } vec_t;
  vec_t vt [13];

  always #5 clk = ~clk;

  assign fifo_empty  = use_model ? (wr_cnt == rd_cnt) : tb_empty;
  assign fifo_rddata = use_model ? m_rddata : tb_rddata;

  // Behavioural FIFO: data one cycle after the strobe, flushed together with the DUT
  always @(posedge clk or posedge srst) begin
    if (srst) begin
      rd_cnt   <= wr_cnt;
      m_rddata <= 8'hEE;
    end else if (use_model && fifo_rd) begin
      m_rddata <= mem[rd_cnt % 64];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  fifo_stream_reader #(.DWIDTH(8), .PKT_LEN(4), .CWIDTH(8)) dut (
    .clk_i        (clk),
    .srst_i       (srst),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_o    (fifo_rd),
    .fifo_rddata_i(fifo_rddata),
    .src_data_o   (src_data),
    .src_valid_o  (src_valid),
    .src_ready_i  (src_ready),
    .src_sop_o    (src_sop),
    .src_eop_o    (src_eop),
    .pkt_cnt_o    (pkt_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic model);
    @(negedge clk);
    srst = 1'b1; src_ready = 1'b0; tb_empty = 1'b1; tb_rddata = 8'h00; use_model = model;
    @(negedge clk);
    @(negedge clk);
    srst = 1'b0;
    nrd = 0; nb = 0; cyc = 0;
    for (int i = 0; i < 16; i++) begin
      b_data[i] = 8'hFF; b_sop[i] = 1'b0; b_eop[i] = 1'b0; b_pkt[i] = 8'hFF; b_cyc[i] = -1;
    end
  endtask

  // One cycle: optional FIFO writes, drive ready, sample and record any transfer
  task automatic step(input logic rdy, input int npush, input logic [7:0] pbase);
    int   out_s;
    logic pop_s;
    @(negedge clk);
    for (int k = 0; k < npush; k++) begin
      mem[wr_cnt % 64] = pbase + 8'(k);
      wr_cnt++;
    end
    src_ready = rdy;
    #1;
    cyc++;
    out_s = nrd - nb;
    pop_s = src_valid && src_ready;
    if (chk_inv && out_s == 2 && !pop_s) chk("no_read_when_full", 32'(fifo_rd), 32'd0);
    if (fifo_rd) nrd++;
    if (pop_s) begin
      if (nb < 16) begin
        b_data[nb] = src_data; b_sop[nb] = src_sop; b_eop[nb] = src_eop;
        b_pkt[nb] = pkt_cnt; b_cyc[nb] = cyc;
      end
      nb++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           empty  rddata  rdy   rd    valid data   sop   eop   pkt
    vt[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0};
    vt[2]  = '{1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0};
    vt[3]  = '{1'b0, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'd0};
    vt[4]  = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 8'd0};
    vt[5]  = '{1'b0, 8'h66, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 8'd0};
    vt[6]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 8'd0};
    vt[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 8'd0};
    vt[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    vt[10] = '{1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
    vt[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'd0};
    vt[12] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1};

    srst = 1'b0; src_ready = 1'b0; tb_empty = 1'b1; tb_rddata = 8'h00; use_model = 1'b0;

    // Reset then idle with an empty FIFO
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tb_empty = 1'b1; src_ready = 1'b1;
      #1;
      chk("idle_rd", 32'(fifo_rd), 32'd0);
      chk("idle_valid", 32'(src_valid), 32'd0);
      chk("idle_pkt", 32'(pkt_cnt), 32'd0);
      if (i == 0) begin
        chk("rst_data", 32'(src_data), 32'd0);
        chk("rst_sop", 32'(src_sop), 32'd1);
        chk("rst_eop", 32'(src_eop), 32'd0);
      end
    end

    // Per-cycle vectors with the FIFO interface driven directly
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      tb_empty = vt[i].empty; tb_rddata = vt[i].rddata; src_ready = vt[i].ready;
      #1;
      chk($sformatf("vec%0d_rd", i), 32'(fifo_rd), 32'(vt[i].rd));
      chk($sformatf("vec%0d_valid", i), 32'(src_valid), 32'(vt[i].valid));
      chk($sformatf("vec%0d_sop", i), 32'(src_sop), 32'(vt[i].sop));
      chk($sformatf("vec%0d_eop", i), 32'(src_eop), 32'(vt[i].eop));
      chk($sformatf("vec%0d_pkt", i), 32'(pkt_cnt), 32'(vt[i].pkt));
      if (vt[i].valid) chk($sformatf("vec%0d_data", i), 32'(src_data), 32'(vt[i].data));
    end

    // A: eight words, sink always ready, back-to-back beats
    do_reset(1'b1);
    step(1'b1, 8, 8'h10);
    chk("A_rd_when_nonempty", 32'(fifo_rd), 32'd1);
    for (int j = 0; j < 20 && nb < 8; j++) step(1'b1, 0, 8'h00);
    chk("A_beats", 32'(nb), 32'd8);
    for (int i = 0; i < 8 && i < nb; i++) begin
      chk($sformatf("A_data%0d", i), 32'(b_data[i]), 32'(8'h10 + 8'(i)));
      chk($sformatf("A_sop%0d", i), 32'(b_sop[i]), 32'((i % 4) == 0));
      chk($sformatf("A_eop%0d", i), 32'(b_eop[i]), 32'((i % 4) == 3));
      chk($sformatf("A_pkt%0d", i), 32'(b_pkt[i]), 32'(i / 4));
      chk($sformatf("A_cyc%0d", i), 32'(b_cyc[i]), 32'(3 + i));
    end
    step(1'b1, 0, 8'h00);
    chk("A_pkt_end", 32'(pkt_cnt), 32'd2);
    chk("A_reads", 32'(nrd), 32'd8);

    // B: ready toggling every cycle, order preserved and buffer never overfilled
    do_reset(1'b1);
    chk_inv = 1'b1;
    step(1'b1, 8, 8'h10);
    for (int j = 1; j < 60 && nb < 8; j++) step((j % 2) == 0, 0, 8'h00);
    chk_inv = 1'b0;
    chk("B_beats", 32'(nb), 32'd8);
    for (int i = 0; i < 8 && i < nb; i++)
      chk($sformatf("B_data%0d", i), 32'(b_data[i]), 32'(8'h10 + 8'(i)));

    // C: long backpressure, only two reads issued, head held stable
    do_reset(1'b1);
    step(1'b0, 8, 8'h10);
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 0, 8'h00);
      if (cyc >= 3) begin
        chk("C_hold_valid", 32'(src_valid), 32'd1);
        chk("C_hold_data", 32'(src_data), 32'h10);
      end
    end
    chk("C_reads", 32'(nrd), 32'd2);
    step(1'b1, 0, 8'h00);
    step(1'b1, 0, 8'h00);
    chk("C_beats", 32'(nb), 32'd2);
    chk("C_first", 32'(b_data[0]), 32'h10);
    chk("C_second", 32'(b_data[1]), 32'h11);
    chk("C_next_cycle", 32'(b_cyc[1]), 32'(b_cyc[0] + 1));

    // D: FIFO runs dry mid-packet, later refill resumes at the right beat position
    do_reset(1'b1);
    step(1'b1, 3, 8'h20);
    for (int j = 2; j < 40 && nb < 8; j++) step(1'b1, (j == 7) ? 5 : 0, 8'h23);
    chk("D_beats", 32'(nb), 32'd8);
    for (int i = 0; i < 8 && i < nb; i++)
      chk($sformatf("D_data%0d", i), 32'(b_data[i]), 32'(8'h20 + 8'(i)));
    chk("D_gap", 32'(b_cyc[3] > b_cyc[2] + 1), 32'd1);
    chk("D_eop3", 32'(b_eop[3]), 32'd1);
    chk("D_sop3", 32'(b_sop[3]), 32'd0);
    chk("D_pkt_at3", 32'(b_pkt[3]), 32'd0);
    chk("D_sop4", 32'(b_sop[4]), 32'd1);
    chk("D_pkt_at4", 32'(b_pkt[4]), 32'd1);

    // E: reset mid-packet with buffered and in-flight data
    do_reset(1'b1);
    step(1'b1, 8, 8'h10);
    for (int j = 0; j < 10 && nb < 2; j++) step(1'b1, 0, 8'h00);
    chk("E_pre_beats", 32'(nb), 32'd2);
    @(negedge clk);
    srst = 1'b1; src_ready = 1'b1;
    #1;
    chk("E_rst_valid", 32'(src_valid), 32'd0);
    chk("E_rst_rd", 32'(fifo_rd), 32'd0);
    chk("E_rst_sop", 32'(src_sop), 32'd1);
    chk("E_rst_pkt", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    srst = 1'b0;
    nrd = 0; nb = 0; cyc = 0;
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 0, 8'h00);
      chk("E_no_stale", 32'(src_valid), 32'd0);
    end
    step(1'b1, 4, 8'h30);
    for (int j = 0; j < 10 && nb < 1; j++) step(1'b1, 0, 8'h00);
    chk("E_post_beats", 32'(nb >= 1), 32'd1);
    chk("E_post_data", 32'(b_data[0]), 32'h30);
    chk("E_post_sop", 32'(b_sop[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
